// File: rtl/dispatch_pkg.sv
// Shared definitions for dispatch_queue: opcode map, opcode-class helpers,
// queue entry layout and the "no dependency" tag.
package dispatch_pkg;

   localparam int DQ_XLEN  = 32;
   localparam int DQ_REG_W = 5;
   localparam int DQ_TAG_W = 4;
   localparam int DQ_OP_W  = 6;

   localparam logic [DQ_TAG_W-1:0] NO_TAG = '0;

   localparam logic [DQ_OP_W-1:0] OP_NOP   = 6'd0;
   localparam logic [DQ_OP_W-1:0] OP_LUI   = 6'd1;
   localparam logic [DQ_OP_W-1:0] OP_AUIPC = 6'd2;
   localparam logic [DQ_OP_W-1:0] OP_JAL   = 6'd3;
   localparam logic [DQ_OP_W-1:0] OP_JALR  = 6'd4;
   localparam logic [DQ_OP_W-1:0] OP_BEQ   = 6'd5;
   localparam logic [DQ_OP_W-1:0] OP_BNE   = 6'd6;
   localparam logic [DQ_OP_W-1:0] OP_BLT   = 6'd7;
   localparam logic [DQ_OP_W-1:0] OP_BGE   = 6'd8;
   localparam logic [DQ_OP_W-1:0] OP_BLTU  = 6'd9;
   localparam logic [DQ_OP_W-1:0] OP_BGEU  = 6'd10;
   localparam logic [DQ_OP_W-1:0] OP_LB    = 6'd11;
   localparam logic [DQ_OP_W-1:0] OP_LH    = 6'd12;
   localparam logic [DQ_OP_W-1:0] OP_LW    = 6'd13;
   localparam logic [DQ_OP_W-1:0] OP_LBU   = 6'd14;
   localparam logic [DQ_OP_W-1:0] OP_LHU   = 6'd15;
   localparam logic [DQ_OP_W-1:0] OP_SB    = 6'd16;
   localparam logic [DQ_OP_W-1:0] OP_SH    = 6'd17;
   localparam logic [DQ_OP_W-1:0] OP_SW    = 6'd18;
   localparam logic [DQ_OP_W-1:0] OP_ADDI  = 6'd19;
   localparam logic [DQ_OP_W-1:0] OP_ADD   = 6'd20;
   localparam logic [DQ_OP_W-1:0] OP_SUB   = 6'd21;

   typedef struct packed {
      logic [DQ_REG_W-1:0] rs1;
      logic [DQ_REG_W-1:0] rs2;
      logic [DQ_REG_W-1:0] rd;
      logic [DQ_XLEN-1:0]  imm;
      logic [DQ_OP_W-1:0]  op;
      logic [DQ_XLEN-1:0]  pc;
      logic [DQ_XLEN-1:0]  target;
      logic                taken;
   } dq_entry_t;

   function automatic logic is_branch(input logic [DQ_OP_W-1:0] op);
      return (op >= OP_BEQ) && (op <= OP_BGEU);
   endfunction

   function automatic logic is_load(input logic [DQ_OP_W-1:0] op);
      return (op >= OP_LB) && (op <= OP_LHU);
   endfunction

   function automatic logic is_store(input logic [DQ_OP_W-1:0] op);
      return (op >= OP_SB) && (op <= OP_SW);
   endfunction

   // Channel 1 is the load/store station, everything else goes to channel 0.
   function automatic logic rs_channel(input logic [DQ_OP_W-1:0] op);
      return is_load(op) || is_store(op);
   endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// Generic DEPTH-entry synchronous FIFO with flush, occupancy count and
// full/empty flags; head data is read combinationally.
module dispatch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [WIDTH-1:0]           wdata_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CNT_FULL);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[head_q];

   // A full queue refuses a push even when the head leaves in the same cycle.
   assign do_push = push_i && !full_o && !flush_i;
   assign do_pop  = pop_i && !empty_o && !flush_i;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (do_push) tail_d = tail_q + PTR_ONE;
         if (do_pop)  head_d = head_q + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[tail_q] <= wdata_i;
   end

endmodule

// File: rtl/dispatch_queue.sv
// Buffered in-order dispatch stage: queues decoded instructions, resolves the
// head's operands and issues it to an RS channel. Option: DISPATCH_BYPASS_EN.
module dispatch_queue
   import dispatch_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int NUM_RS = 2,
   parameter int XLEN   = 32,
   parameter int REG_W  = 5,
   parameter int TAG_W  = 4,
   parameter int OP_W   = 6
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              flush_in,
   input  logic              dec_valid_in,
   output logic              dec_ready_out,
   input  logic [REG_W-1:0]  dec_rs1_in,
   input  logic [REG_W-1:0]  dec_rs2_in,
   input  logic [REG_W-1:0]  dec_rd_in,
   input  logic [XLEN-1:0]   dec_imm_in,
   input  logic [OP_W-1:0]   dec_op_in,
   input  logic [XLEN-1:0]   dec_pc_in,
   input  logic [XLEN-1:0]   dec_target_in,
   input  logic              dec_taken_in,
   output logic [REG_W-1:0]  rf_rs1_out,
   output logic [REG_W-1:0]  rf_rs2_out,
   input  logic              rf_busy1_in,
   input  logic              rf_busy2_in,
   input  logic [XLEN-1:0]   rf_val1_in,
   input  logic [XLEN-1:0]   rf_val2_in,
   input  logic [TAG_W-1:0]  rf_tag1_in,
   input  logic [TAG_W-1:0]  rf_tag2_in,
   output logic              rf_ren_en_out,
   output logic [REG_W-1:0]  rf_ren_rd_out,
   output logic [TAG_W-1:0]  rf_ren_tag_out,
   output logic [TAG_W-1:0]  rob_h1_out,
   output logic [TAG_W-1:0]  rob_h2_out,
   input  logic              rob_ready1_in,
   input  logic              rob_ready2_in,
   input  logic [XLEN-1:0]   rob_val1_in,
   input  logic [XLEN-1:0]   rob_val2_in,
   input  logic              rob_full_in,
   input  logic [TAG_W-1:0]  rob_tail_in,
   output logic              rob_en_out,
   output logic [OP_W-1:0]   rob_op_out,
   output logic [REG_W-1:0]  rob_rd_out,
   output logic [XLEN-1:0]   rob_pc_out,
   output logic [XLEN-1:0]   rob_target_out,
   output logic              rob_taken_out,
   input  logic [NUM_RS-1:0] rs_full_in,
   output logic [NUM_RS-1:0] rs_en_out,
   output logic [OP_W-1:0]   rs_op_out,
   output logic [XLEN-1:0]   rs_pc_out,
   output logic [XLEN-1:0]   rs_a_out,
   output logic [TAG_W-1:0]  rs_dest_out,
   output logic [XLEN-1:0]   rs_vj_out,
   output logic [XLEN-1:0]   rs_vk_out,
   output logic [TAG_W-1:0]  rs_qj_out,
   output logic [TAG_W-1:0]  rs_qk_out,
   input  logic              cdb_en_in,
   input  logic [TAG_W-1:0]  cdb_tag_in,
   input  logic [XLEN-1:0]   cdb_val_in
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

   dq_entry_t        dec_entry, fifo_rdata, head;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full, fifo_empty;
   logic             bypass, head_valid, ch, fire, push, pop, flush;

   // First-match operand resolution; returns {value, tag}.
   function automatic logic [XLEN+TAG_W-1:0] resolve(
      input logic [REG_W-1:0] r,
      input logic             busy,
      input logic [XLEN-1:0]  rf_val,
      input logic [TAG_W-1:0] tag,
      input logic             rob_ready,
      input logic [XLEN-1:0]  rob_val,
      input logic             cdb_en,
      input logic [TAG_W-1:0] cdb_tag,
      input logic [XLEN-1:0]  cdb_val
   );
      if (r == '0)                      return {{XLEN{1'b0}}, NO_TAG};
      else if (!busy)                   return {rf_val, NO_TAG};
      else if (rob_ready)               return {rob_val, NO_TAG};
      else if (cdb_en && cdb_tag == tag) return {cdb_val, NO_TAG};
      else                              return {{XLEN{1'b0}}, tag};
   endfunction

   always_comb begin
      dec_entry        = '0;
      dec_entry.rs1    = dec_rs1_in;
      dec_entry.rs2    = dec_rs2_in;
      dec_entry.rd     = dec_rd_in;
      dec_entry.imm    = dec_imm_in;
      dec_entry.op     = dec_op_in;
      dec_entry.pc     = dec_pc_in;
      dec_entry.target = dec_target_in;
      dec_entry.taken  = dec_taken_in;
   end

`ifdef DISPATCH_BYPASS_EN
   assign bypass = fifo_empty && dec_valid_in;
`else
   assign bypass = 1'b0;
`endif

   assign head       = bypass ? dec_entry : fifo_rdata;
   assign head_valid = !fifo_empty || bypass;
   assign ch         = rs_channel(head.op);
   assign fire       = head_valid && !rob_full_in && !rs_full_in[ch] && rdy_in && !flush_in;
   assign pop        = fire && !bypass;
   // A bypassed instruction that fires never enters the queue.
   assign push       = dec_valid_in && rdy_in && !flush_in && !(bypass && fire);
   assign flush      = flush_in && rdy_in;

   assign dec_ready_out = (fifo_count < CNT_DEPTH);

   dispatch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(dq_entry_t))
   ) u_fifo (
      .clk_i   (clk_in),
      .rst_i   (rst_in),
      .flush_i (flush),
      .push_i  (push && !fifo_full),
      .pop_i   (pop),
      .wdata_i (dec_entry),
      .rdata_o (fifo_rdata),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      rf_rs1_out     = '0;
      rf_rs2_out     = '0;
      rob_h1_out     = '0;
      rob_h2_out     = '0;
      rf_ren_rd_out  = '0;
      rf_ren_tag_out = '0;
      rob_op_out     = '0;
      rob_rd_out     = '0;
      rob_pc_out     = '0;
      rob_target_out = '0;
      rob_taken_out  = 1'b0;
      rs_op_out      = '0;
      rs_pc_out      = '0;
      rs_a_out       = '0;
      rs_dest_out    = '0;
      rs_vj_out      = '0;
      rs_vk_out      = '0;
      rs_qj_out      = '0;
      rs_qk_out      = '0;
      rs_en_out      = '0;
      rob_en_out     = 1'b0;
      rf_ren_en_out  = 1'b0;
      if (head_valid) begin
         rf_rs1_out     = head.rs1;
         rf_rs2_out     = head.rs2;
         rob_h1_out     = rf_tag1_in;
         rob_h2_out     = rf_tag2_in;
         rf_ren_rd_out  = head.rd;
         rf_ren_tag_out = rob_tail_in;
         rob_op_out     = head.op;
         rob_rd_out     = head.rd;
         rob_pc_out     = head.pc;
         rob_target_out = head.target;
         rob_taken_out  = head.taken;
         rs_op_out      = head.op;
         rs_pc_out      = head.pc;
         rs_a_out       = head.imm;
         rs_dest_out    = rob_tail_in;
         {rs_vj_out, rs_qj_out} = resolve(head.rs1, rf_busy1_in, rf_val1_in, rf_tag1_in,
                                          rob_ready1_in, rob_val1_in,
                                          cdb_en_in, cdb_tag_in, cdb_val_in);
         {rs_vk_out, rs_qk_out} = resolve(head.rs2, rf_busy2_in, rf_val2_in, rf_tag2_in,
                                          rob_ready2_in, rob_val2_in,
                                          cdb_en_in, cdb_tag_in, cdb_val_in);
      end
      if (fire) begin
         rs_en_out[ch] = 1'b1;
         rob_en_out    = 1'b1;
         rf_ren_en_out = !is_branch(head.op) && !is_store(head.op) && (head.rd != '0);
      end
   end

endmodule
